// File: rtl/moka_rv32i_mem_pkg.sv
// -----------------------------------------------------------------------------
// moka_rv32i_mem_pkg
//   Shared types and defaults for the RV32I data-memory arbiter slice.
//   - MEM_ADDR_W / MEM_DATA_W : default bus widths of the data-memory port
//   - owner_e                 : bus owner recorded by the arbiter FSM
//   - mem_req_t               : one master's request fields {we, address, wr_data}
//   - owner_of()              : maps a granted master index to its owner state
// -----------------------------------------------------------------------------
package moka_rv32i_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] address;
        logic [MEM_DATA_W-1:0] wr_data;
    } mem_req_t;

    function automatic owner_e owner_of(input logic idx);
        return idx ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/moka_rr_arb2.sv
// -----------------------------------------------------------------------------
// moka_rr_arb2
//   Pure combinational 2-way grant logic: round-robin between two masters
//   with a bounded bus lock for the current owner.
//   Ports:
//     req[1:0]        per-master request
//     lock[1:0]       per-master hold-bus hint (only meaningful with req)
//     owner           current owner state (OWN_IDLE / OWN_M0 / OWN_M1)
//     last_served     index of the master granted most recently
//     burst_cnt       consecutive grants already given to the owner
//     en              enable; low forces no grant
//     gnt[1:0]        one-hot grant, or zero
// -----------------------------------------------------------------------------
module moka_rr_arb2
    import moka_rv32i_mem_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  owner_e           owner,
    input  logic             last_served,
    input  logic [CNT_W-1:0] burst_cnt,
    input  logic             en,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic own_idx;
    logic lock_hold;

    always_comb begin
        gnt       = 2'b00;
        own_idx   = (owner == OWN_M1);
        // The lock only binds while the owner keeps asking with its hint set
        // and has not yet used up its burst allowance.
        lock_hold = (owner != OWN_IDLE) && req[own_idx] && lock[own_idx] &&
                    (burst_cnt < CNT_MAX);

        if (en) begin
            if (lock_hold) begin
                gnt[own_idx] = 1'b1;
            end else if (req == 2'b11) begin
                // Tie: the master that was not served last wins. An owner
                // whose burst is exhausted is always last_served, so this
                // also hands the bus over once the lock allowance runs out.
                gnt = last_served ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/moka_rv32i_mem_arbiter.sv
// -----------------------------------------------------------------------------
// moka_rv32i_mem_arbiter
//   Shares the single data-memory port of the RV32I system between the
//   load/store unit (master 0) and a debug/program-loader master (master 1).
//   Grants are combinational in the request cycle; read data returns one
//   cycle later, flagged only to the master that issued the read.
//   Ports:
//     clk, rstn        clock (rising edge), synchronous active-low reset
//     en               arbiter enable; low blocks new grants
//     m_req/m_lock     per-master request and hold-bus hint
//     m_we/m_address/m_wr_data  per-master access fields
//     m_gnt            one-hot (or zero) grant, same cycle
//     m_rvalid         registered per-master read-return flag
//     m_rd_data        shared read data, zero unless an rvalid is set
//     mem_en/mem_we/address/wr_data  memory-side request (zero when idle)
//     rd_data          memory read data, valid one cycle after a read strobe
// -----------------------------------------------------------------------------
module moka_rv32i_mem_arbiter
    import moka_rv32i_mem_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic [1:0]             m_req,
    input  logic [1:0]             m_lock,
    input  logic [1:0]             m_we,
    input  logic [1:0][ADDR_W-1:0] m_address,
    input  logic [1:0][DATA_W-1:0] m_wr_data,
    output logic [1:0]             m_gnt,
    output logic [1:0]             m_rvalid,
    output logic [DATA_W-1:0]      m_rd_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      address,
    output logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      rd_data
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    owner_e           owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       arb_gnt;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic [1:0]       rd_gnt;
    logic [1:0]       vld_p1;

    moka_rr_arb2 #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_arb (
        .req         (m_req),
        .lock        (m_lock),
        .owner       (owner_q),
        .last_served (last_q),
        .burst_cnt   (cnt_q),
        .en          (en),
        .gnt         (arb_gnt)
    );

    // Reset also silences the combinational grant so nothing reaches memory
    // while rstn is low.
    always_comb begin
        gnt     = rstn ? arb_gnt : 2'b00;
        gnt_idx = gnt[1];
        rd_gnt  = gnt & ~m_we;
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (|gnt) begin
            owner_d = owner_of(gnt_idx);
            last_d  = gnt_idx;
            if (owner_q != owner_of(gnt_idx)) begin
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end else begin
            // Any cycle without a grant (idle, en low) releases ownership;
            // the burst count is kept and restarts on the next grant.
            owner_d = OWN_IDLE;
        end
    end

    always_comb begin
        m_gnt   = gnt;
        mem_en  = |gnt;
        mem_we  = 1'b0;
        address = '0;
        wr_data = '0;
        if (|gnt) begin
            mem_we  = m_we[gnt_idx];
            address = m_address[gnt_idx];
            wr_data = m_wr_data[gnt_idx];
        end
    end

    // ---- stage p0 -> p1: arbitration state and read-return flag ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_q <= OWN_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            vld_p1  <= 2'b00;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            vld_p1  <= rd_gnt;
        end
    end

    // ---- stage p1: read return ----
    always_comb begin
        m_rvalid  = vld_p1;
        m_rd_data = (|vld_p1) ? rd_data : '0;
    end

endmodule
